// File: rtl/adder_pkg.sv
// Shared constants for the adder library.
// Widths are bounded so that the ripple chain stays within one clock period.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 8;
  localparam int ADDER_WIDTH_MAX     = 64;

endpackage

// File: rtl/full_adder.sv
// Purely combinational one-bit full adder: two half-adder stages joined by an OR.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // The first stage adds the operands and the second stage folds in the incoming carry.
  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;
  assign sum       = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;
  assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/full_adder_core.sv
// Registered ripple-carry adder built from a chain of full_adder cells.
// Define FULL_ADDER_CORE_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_core
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FULL_ADDER_CORE_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Each cell's carry output feeds the carry input of the next cell up.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder u_fa (
        .a     (a[gi]),
        .b     (b[gi]),
        .cin   (c[gi]),
        .sum   (s[gi]),
        .carry (c[gi+1])
      );
    end
  endgenerate

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

`ifdef FULL_ADDER_CORE_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow occurs when the carries into and out of the sign bit disagree.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Directed and random checks of full_adder_core at WIDTH 8, 1 and 32.
module tb_full_adder_core;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic [31:0] a32 = '0, b32 = '0;

  logic        ov8, ov1, ov32;
  logic [7:0]  s8;
  logic [0:0]  s1;
  logic [31:0] s32;
  logic        c8, c1, c32;
`ifdef FULL_ADDER_CORE_OVF_EN
  logic        f8, f1, f32;
`endif

  int checks = 0;
  int passed = 0;

  always #5 if (clk_en) clk = ~clk;

  full_adder_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
    .out_valid(ov8), .sum(s8), .carry(c8)
`ifdef FULL_ADDER_CORE_OVF_EN
    , .ovf(f8)
`endif
  );

  full_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
    .out_valid(ov1), .sum(s1), .carry(c1)
`ifdef FULL_ADDER_CORE_OVF_EN
    , .ovf(f1)
`endif
  );

  full_adder_core #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a32), .b(b32), .cin(cin),
    .out_valid(ov32), .sum(s32), .carry(c32)
`ifdef FULL_ADDER_CORE_OVF_EN
    , .ovf(f32)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation on the 8-bit instance and sample just after the next edge.
  task automatic op8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    in_valid = v;
    a8 = a;
    b8 = b;
    cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [7:0] s, input logic c);
    chk({tag, ".valid"}, {63'd0, ov8}, {63'd0, v});
    chk({tag, ".sum_carry"}, {55'd0, c8, s8}, {55'd0, c, s});
    $display("%s: a=%02h b=%02h cin=%0d -> out_valid=%0d carry=%0d sum=%02h",
             tag, a8, b8, cin, ov8, c8, s8);
  endtask

  logic [8:0]  m8;
  logic [1:0]  m1;
  logic [32:0] m32;
  logic        v;
`ifdef FULL_ADDER_CORE_OVF_EN
  logic        mf8;
`endif

  initial begin
    // Reset with no clock running.
    #2;
    rst = 1'b1;
    #1;
    chk("reset_noclk.sum_carry", {55'd0, c8, s8}, 64'd0);
    chk("reset_noclk.valid", {63'd0, ov8}, 64'd0);
`ifdef FULL_ADDER_CORE_OVF_EN
    chk("reset_noclk.ovf", {63'd0, f8}, 64'd0);
`endif
    $display("reset asserted without clock: out_valid=%0d carry=%0d sum=%02h", ov8, c8, s8);

    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op8(1'b0, 8'h00, 8'h00, 1'b0);
    op8(1'b0, 8'h00, 8'h00, 1'b0);
    chk8("post_reset_idle", 1'b0, 8'h00, 1'b0);

    op8(1'b1, 8'h9A, 8'h92, 1'b0);
    chk8("cin0", 1'b1, 8'h2C, 1'b1);
    op8(1'b1, 8'h9A, 8'h92, 1'b1);
    chk8("cin1", 1'b1, 8'h2D, 1'b1);
    op8(1'b1, 8'hFF, 8'h00, 1'b1);
    chk8("ripple_ff_00", 1'b1, 8'h00, 1'b1);
    op8(1'b1, 8'hFF, 8'hFF, 1'b1);
    chk8("ripple_ff_ff", 1'b1, 8'hFF, 1'b1);

    op8(1'b1, 8'h01, 8'h02, 1'b0);
    chk8("pipe0", 1'b1, 8'h03, 1'b0);
    op8(1'b1, 8'h10, 8'h20, 1'b1);
    chk8("pipe1", 1'b1, 8'h31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op8(1'b0, 8'hAA, 8'h55, 1'b1);
      chk8($sformatf("hold%0d", i), 1'b0, 8'h31, 1'b0);
    end

`ifdef FULL_ADDER_CORE_OVF_EN
    op8(1'b1, 8'h7F, 8'h01, 1'b0);
    chk8("ovf_pos", 1'b1, 8'h80, 1'b0);
    chk("ovf_pos.ovf", {63'd0, f8}, 64'd1);
    op8(1'b1, 8'h80, 8'h80, 1'b0);
    chk8("ovf_neg", 1'b1, 8'h00, 1'b1);
    chk("ovf_neg.ovf", {63'd0, f8}, 64'd1);
    op8(1'b1, 8'h40, 8'h01, 1'b0);
    chk8("ovf_none", 1'b1, 8'h41, 1'b0);
    chk("ovf_none.ovf", {63'd0, f8}, 64'd0);
`endif

    // Reset asserted while an operation is pending discards it.
    @(negedge clk);
    in_valid = 1'b1;
    a8 = 8'h12;
    b8 = 8'h34;
    cin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk8("midreset", 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk8("midreset_edge", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    op8(1'b1, 8'h12, 8'h34, 1'b1);
    chk8("after_reset", 1'b1, 8'h47, 1'b0);

    // Random phase across all three widths; the first op is forced valid to seed the models.
    m8 = '0;
    m1 = '0;
    m32 = '0;
`ifdef FULL_ADDER_CORE_OVF_EN
    mf8 = 1'b0;
`endif
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = v;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      cin = 1'($urandom);
      if (v) begin
        m8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin};
        m1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
        m32 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin};
`ifdef FULL_ADDER_CORE_OVF_EN
        mf8 = (a8[7] == b8[7]) && (m8[7] != a8[7]);
`endif
      end
      @(posedge clk);
      #1;
      chk("rand_w8", {54'd0, ov8, c8, s8}, {54'd0, v, m8});
      chk("rand_w1", {61'd0, ov1, c1, s1}, {61'd0, v, m1});
      chk("rand_w32", {30'd0, ov32, c32, s32}, {30'd0, v, m32});
`ifdef FULL_ADDER_CORE_OVF_EN
      chk("rand_w8_ovf", {63'd0, f8}, {63'd0, mf8});
`endif
      $display("rand %0d: valid=%0d w8=%03h w1=%01h w32=%09h", i, v, {c8, s8}, {c1, s1}, {c32, s32});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
